// File: rtl/data_memory.sv
// Block-organised data memory behind the data cache.
// Each accepted read or write is held for LATENCY busy cycles, then completes
// and reports one DONE cycle with busywait low before the next request is taken.
module data_memory #(
  parameter int LATENCY    = 5,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         read,
  input  logic         write,
  input  logic [27:0]  address,
  input  logic [127:0] writedata,
  output logic [127:0] readdata,
  output logic         busywait
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [7:0] COUNT_LOAD = 8'(LATENCY - 1);

  logic [1:0]   state;
  logic [7:0]   count;

  // Request captured at acceptance; the requester may change its inputs afterwards.
  logic [27:0]  addr_p0;
  logic [127:0] wdata_p0;
  logic         op_wr_p0;

  // Array starts out zeroed and is deliberately left untouched by reset.
  logic [127:0] mem [2**DEPTH_LOG2] = '{default: '0};

  logic [DEPTH_LOG2-1:0] index_p0;
  logic                  access_now;

  // Upper address bits alias onto the same block; they are carried but never used.
  logic unused_addr_hi;

  assign index_p0       = addr_p0[DEPTH_LOG2-1:0];
  assign access_now     = (state == BUSY) && (count == 8'd0);
  assign unused_addr_hi = ^addr_p0[27:DEPTH_LOG2];

  // In IDLE the requester sees busy in the same cycle it raises a request.
  always_comb begin
    busywait = 1'b0;
    case (state)
      IDLE:    busywait = read | write;
      BUSY:    busywait = 1'b1;
      DONE:    busywait = 1'b0;
      default: busywait = 1'b0;
    endcase
  end

  // Control FSM, request capture and read return.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      addr_p0  <= '0;
      wdata_p0 <= '0;
      op_wr_p0 <= 1'b0;
      readdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (read | write) begin
            addr_p0  <= address;
            wdata_p0 <= writedata;
            op_wr_p0 <= write;          // write wins when both are raised
            count    <= COUNT_LOAD;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (count == 8'd0) begin
            if (!op_wr_p0) begin
              readdata <= mem[index_p0];
            end
            state <= DONE;
          end else begin
            count <= count - 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;                // requests still held here are ignored
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Array update; a reset arriving on the completing edge aborts the write.
  always_ff @(posedge clock) begin
    if (reset && access_now && op_wr_p0) begin
      mem[index_p0] <= wdata_p0;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: vector table plus hand-written
// reset-abort and back-to-back sequences.
module tb_data_memory;

  localparam int LAT = 5;
  localparam int EXP_BUSY = LAT + 1;   // request cycle plus LATENCY busy cycles

  logic         clock;
  logic         reset;
  logic         read;
  logic         write;
  logic [27:0]  address;
  logic [127:0] writedata;
  logic [127:0] readdata;
  logic         busywait;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  data_memory #(.LATENCY(LAT), .DEPTH_LOG2(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .read      (read),
    .write     (write),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .busywait  (busywait)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete access: drive the request, scramble address/data while busy,
  // stop at the first cycle where busywait is low (the DONE cycle).
  task automatic do_access(input logic rd, input logic wr, input logic [27:0] a,
                           input logic [127:0] d, output int nbusy,
                           output logic [127:0] rdata_done, output int start_cyc,
                           output int done_cyc);
    bit done;
    @(posedge clock); #1;
    read = rd; write = wr; address = a; writedata = d;
    start_cyc  = cyc;
    nbusy      = 0;
    done       = 0;
    rdata_done = '0;
    done_cyc   = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clock);
      if (busywait) begin
        nbusy++;
        @(posedge clock); #1;
        address   = ~a;
        writedata = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        done       = 1;
        rdata_done = readdata;
        done_cyc   = cyc;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: busywait stuck high, got %0d cycles required %0d", nbusy, EXP_BUSY);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, sc, dc, sc2, dc2;
    logic [127:0] rd_v;
    logic [127:0] d1, d2, d3, ones;

    d1   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    d2   = 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;
    d3   = 128'h5555_AAAA_0F0F_F0F0_1234_5678_9ABC_DEF0;
    ones = '1;

    vecs[0] = '{1'b0, 1'b1, 28'h0000005, d1,   128'h0};  // write, readdata untouched
    vecs[1] = '{1'b1, 1'b0, 28'h0000005, '0,   d1};
    vecs[2] = '{1'b1, 1'b0, 28'h0000007, '0,   128'h0};  // never written
    vecs[3] = '{1'b0, 1'b1, 28'h0000003, d2,   128'h0};
    vecs[4] = '{1'b1, 1'b0, 28'h0000103, '0,   d2};      // alias of 0x3
    vecs[5] = '{1'b1, 1'b1, 28'h0000010, ones, d2};      // write wins
    vecs[6] = '{1'b1, 1'b0, 28'h0000010, '0,   ones};
    vecs[7] = '{1'b1, 1'b0, 28'h0000005, '0,   d1};

    // Reset state
    reset = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_busywait", {127'b0, busywait}, 128'h0);
    check("reset_readdata", readdata, 128'h0);
    @(posedge clock); #1;
    read = 1'b1;
    @(negedge clock);
    check("reset_busywait_follows_req", {127'b0, busywait}, 128'h1);
    @(posedge clock); #1;
    read = 1'b0;
    reset = 1'b1;

    // Table-driven accesses
    for (int i = 0; i < 8; i++) begin
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, nb, rd_v, sc, dc);
      check($sformatf("vec%0d_busy_cycles", i), 128'(nb), 128'(EXP_BUSY));
      check($sformatf("vec%0d_readdata", i), rd_v, vecs[i].exp_rdata);
    end

    // Reset during the third busy cycle of a write to 0x20
    @(posedge clock); #1;
    read = 1'b0; write = 1'b1; address = 28'h0000020; writedata = d3;
    @(negedge clock);
    check("abort_req_busywait", {127'b0, busywait}, 128'h1);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0; write = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("abort_busywait_idle", {127'b0, busywait}, 128'h0);
    check("abort_readdata_cleared", readdata, 128'h0);
    do_access(1'b1, 1'b0, 28'h0000020, '0, nb, rd_v, sc, dc);
    check("abort_read_busy_cycles", 128'(nb), 128'(EXP_BUSY));
    check("abort_write_suppressed", rd_v, 128'h0);

    // Back-to-back write then held read, no gap after DONE
    do_access(1'b0, 1'b1, 28'h000000A, d3, nb, rd_v, sc, dc);
    check("b2b_write_busy_cycles", 128'(nb), 128'(EXP_BUSY));
    do_access(1'b1, 1'b0, 28'h000000B, '0, nb, rd_v, sc2, dc2);
    check("b2b_read_busy_cycles", 128'(nb), 128'(EXP_BUSY));
    check("b2b_read_readdata", rd_v, 128'h0);
    check("b2b_no_gap", 128'(sc2 - dc), 128'd1);
    check("b2b_total_cycles", 128'(dc2 - sc + 1), 128'(2 * (LAT + 2)));

    do_access(1'b1, 1'b0, 28'h000000A, '0, nb, rd_v, sc, dc);
    check("b2b_write_readback", rd_v, d3);

    // readdata holds across idle cycles and a subsequent write
    @(posedge clock); #1;
    read = 1'b0; write = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("hold_idle_readdata", readdata, d3);
    do_access(1'b0, 1'b1, 28'h000000A, ones, nb, rd_v, sc, dc);
    check("hold_after_write_readdata", rd_v, d3);
    @(posedge clock); #1;
    read = 1'b0; write = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
